// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with bubble insertion, flush and a multi-cycle side buffer.
// Latency: 1 cycle input to output on advance; all outputs registered, no comb path.
// Backpressure: stall[STAGE] stops this slot, and stall[STAGE+1] decides between bubble and hold.
// Optional: define PIPE_STALL_CNT_EN to enable the saturating consecutive-stall counter.
module pipe_stage_reg #(
  parameter int                DATA_W  = 128,
  parameter int                SIDE_W  = 66,
  parameter int                STALL_W = 6,
  parameter int                STAGE   = 3,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SIDE_W-1:0]  side_i,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SIDE_W-1:0]  side_o,
  output logic               bubble_o,
  output logic [15:0]        stall_cnt_o
);

  // Masks pick this boundary's two stall bits; all other stall bits are ignored.
  localparam logic [STALL_W-1:0] UP_MASK = STALL_W'(1) << STAGE;
  localparam logic [STALL_W-1:0] DN_MASK = STALL_W'(1) << (STAGE + 1);

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_ADVANCE = 2'd2,
    ACT_HOLD    = 2'd3
  } act_e;

  logic              up_stall;
  logic              dn_stall;
  act_e              act;

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [SIDE_W-1:0] side_q,   side_d;
  logic              bubble_q, bubble_d;

  assign up_stall = |(stall & UP_MASK);
  assign dn_stall = |(stall & DN_MASK);

  // Priority decode: flush beats everything; downstream-only stall is treated as advance.
  always_comb begin
    act = ACT_ADVANCE;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (up_stall && !dn_stall) begin
      act = ACT_BUBBLE;
    end else if (up_stall && dn_stall) begin
      act = ACT_HOLD;
    end
  end

  // Next-state for the slot: side buffer tracks the unit while stalled, clears when the slot moves.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    bubble_d = bubble_q;
    side_d   = side_i;
    case (act)
      ACT_FLUSH: begin
        valid_d  = 1'b0;
        data_d   = NOP_VAL;
        bubble_d = 1'b0;
        side_d   = '0;
      end
      ACT_BUBBLE: begin
        valid_d  = 1'b0;
        data_d   = NOP_VAL;
        bubble_d = 1'b1;
      end
      ACT_ADVANCE: begin
        valid_d  = in_valid;
        data_d   = in_data;
        bubble_d = 1'b0;
        side_d   = '0;
      end
      default: ; // hold: slot keeps its contents
    endcase
  end

  // Slot registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      data_q   <= NOP_VAL;
      side_q   <= '0;
      bubble_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      side_q   <= side_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign side_o    = side_q;
  assign bubble_o  = bubble_q;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count consecutive bubble/hold edges, saturating so the perf monitor never sees a wrap.
  always_comb begin
    cnt_d = 16'h0000;
    if (act == ACT_BUBBLE || act == ACT_HOLD) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h0001;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule
